oflow_pe_match_ctrl: RTL
========================

OFLOW_PE_MATCH_CTRL -- requirements
Module: oflow_pe_match_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
- NUM_CH, 2, parallel similarity-metric channels per row.
- SCORE_W, 16, score width.
- ID_W, 12, object ID width.
- ROW_W, 6, row_sel width.
- CNT_W, 10, previous-object count width.
REQ-002 SHALL use one clock; reset is asynchronous and active-low (clk, reset_N).
REQ-003 SHALL have these ports, one per line:
- clk  in  1  clock.
- reset_N  in  1  async active-low reset.
- start_pe  in  1  start one bbox (pulse).
- flush  in  1  sync abort to IDLE.
- first_frame  in  1  no previous objects to match.
- num_prev_objs  in  CNT_W  valid previous objects.
- threshold  in  SCORE_W  max score accepted as a match.
- start_fe  out  1  feature-extraction start pulse.
- done_fe  in  1  feature extraction finished.
- row_req  out  1  row request valid.
- row_sel  out  ROW_W  requested row.
- sm_valid  in  1  channel scores valid.
- sm_score  in  NUM_CH*SCORE_W  per-channel score (channel 0 = LSBs).
- sm_id  in  NUM_CH*ID_W  per-channel object ID.
- best_id  out  ID_W  winning ID.
- best_score  out  SCORE_W  winning score.
- matched  out  1  best_score <= threshold.
- done_pe  out  1  result valid pulse.
- busy  out  1  state != IDLE.

Function
REQ-004 SHALL implement FSM states IDLE, FE, REG, DRAIN, DONE.
REQ-005 SHALL, in IDLE on start_pe=1, latch num_prev_objs/first_frame/threshold, pulse start_fe for exactly 1 cycle, and go to FE; start_pe outside IDLE SHALL be ignored.
REQ-006 SHALL, in FE on done_fe=1, go to DONE with matched=0 when first_frame=1 or the latched count=0; otherwise go to REG.
REQ-007 SHALL compute rows = ceil(count/NUM_CH); in REG, row_req=1 with row_sel=0,1,...,rows-1 on consecutive cycles, then go to DRAIN.
REQ-008 SHALL accept sm_valid in REG or DRAIN only; the k-th sm_valid pulse corresponds to row k (in order, any latency >= 1 cycle); sm_valid in other states SHALL be ignored.
REQ-009 SHALL ignore channel c of row k when k*NUM_CH+c >= count (partial last row).
REQ-010 SHALL initialise best_score to all-ones and best_id to 0 on entry to REG; a candidate replaces the best only when strictly less; ties keep the lower candidate index (earlier row, then lower channel).
REQ-011 SHALL go from DRAIN to DONE one cycle after the response count reaches rows.
REQ-012 SHALL, in DONE, set matched = (best_score <= threshold) unsigned, pulse done_pe for 1 cycle, and return to IDLE.
REQ-013 SHALL hold best_id/best_score/matched from done_pe until the next done_pe.
REQ-014 SHALL, on flush=1 in any state, go to IDLE next cycle with row_req, start_fe and done_pe at 0 and no done_pe for the aborted bbox; flush has priority over start_pe.
REQ-015 SHALL register all outputs; busy is the only output that may decode state combinationally.

Reset
REQ-016 SHALL, while reset_N=0, force state IDLE, all counters 0, and every output to 0 (best_score included).
REQ-017 SHALL treat reset mid-operation like flush, with no done_pe issued afterwards.

Verification
REQ-018 NUM_CH=2, count=5, scores {40,12,30,12,90}, IDs 1..5, threshold=20 -> rows 0..2 requested; best_id=2, best_score=12, matched=1, one done_pe.
REQ-019 first_frame=1 -> start_fe pulse, no row_req, done_pe 1 cycle after done_fe, matched=0.
REQ-020 count=3, NUM_CH=2, channel 1 of row 1 scores 0 -> that candidate is ignored; result is the best of the first 3 candidates.
REQ-021 sm_valid latency 4 cycles, all scores 50, threshold=49 -> DRAIN waits for all responses; best_id=first ID, matched=0.
REQ-022 flush in REG after row 1, then a new start_pe -> no done_pe for the first bbox; the second bbox completes correctly.
REQ-023 start_pe held high throughout and sm_valid driven while IDLE -> exactly one operation per IDLE entry; stray sm_valid has no effect.

Source files
------------

// File: rtl/oflow_pe_match_ctrl.sv
// ---------------------------------------------------------------------------
// oflow_pe_match_ctrl
//
// Per-bbox control for the optical-flow processing element. For each
// bounding box it:
//   1. kicks off feature extraction (start_fe) and waits for done_fe,
//   2. streams row requests (row_req/row_sel) to the similarity-metric
//      array, one row per cycle, NUM_CH previous objects per row,
//   3. folds the returned per-channel scores into a running minimum,
//   4. reports the winning ID and score, plus a threshold match flag,
//      with a one-cycle done_pe pulse.
// A first frame, or a frame with no previous objects, skips straight to
// the result with matched=0.
//
// Ports
//   clk, reset_N        clock, asynchronous active-low reset
//   start_pe            start one bbox (ignored unless idle)
//   flush               synchronous abort back to idle
//   first_frame         no previous objects to match against
//   num_prev_objs       number of valid previous objects
//   threshold           largest score still counted as a match
//   start_fe / done_fe  feature-extraction handshake
//   row_req / row_sel   row request to the similarity-metric array
//   sm_valid            one pulse per requested row, in request order
//   sm_score / sm_id    per-channel scores and IDs (channel 0 in LSBs)
//   best_id/best_score  winning candidate, held until the next done_pe
//   matched             best_score <= threshold
//   done_pe             result-valid pulse
//   busy                controller is not idle
// ---------------------------------------------------------------------------
module oflow_pe_match_ctrl #(
    parameter int NUM_CH  = 2,
    parameter int SCORE_W = 16,
    parameter int ID_W    = 12,
    parameter int ROW_W   = 6,
    parameter int CNT_W   = 10
) (
    input  logic                        clk,
    input  logic                        reset_N,
    input  logic                        start_pe,
    input  logic                        flush,
    input  logic                        first_frame,
    input  logic [CNT_W-1:0]            num_prev_objs,
    input  logic [SCORE_W-1:0]          threshold,
    output logic                        start_fe,
    input  logic                        done_fe,
    output logic                        row_req,
    output logic [ROW_W-1:0]            row_sel,
    input  logic                        sm_valid,
    input  logic [NUM_CH*SCORE_W-1:0]   sm_score,
    input  logic [NUM_CH*ID_W-1:0]      sm_id,
    output logic [ID_W-1:0]             best_id,
    output logic [SCORE_W-1:0]          best_score,
    output logic                        matched,
    output logic                        done_pe,
    output logic                        busy
);

    // Candidate-index width: wide enough for rows*NUM_CH without wrapping.
    localparam int IDX_W = CNT_W + $clog2(NUM_CH) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FE,
        ST_REG,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t               state_reg, state_next;

    // Per-bbox latched parameters
    logic [CNT_W-1:0]     count_reg;
    logic                 first_frame_reg;
    logic [SCORE_W-1:0]   threshold_reg;
    logic [CNT_W-1:0]     rows_reg;

    // Progress counters
    logic [CNT_W-1:0]     req_cnt_reg;    // rows requested so far
    logic [CNT_W-1:0]     resp_cnt_reg;   // rows answered so far
    logic [IDX_W-1:0]     base_reg;       // candidate index of channel 0 of next response

    // Running minimum; kept apart from the outputs so the previous result
    // stays visible while a new bbox is being scored.
    logic [SCORE_W-1:0]   run_score_reg;
    logic [ID_W-1:0]      run_id_reg;

    // Registered outputs
    logic                 start_fe_reg, start_fe_next;
    logic                 row_req_reg, row_req_next;
    logic [ROW_W-1:0]     row_sel_reg, row_sel_next;
    logic [ID_W-1:0]      best_id_reg, best_id_next;
    logic [SCORE_W-1:0]   best_score_reg, best_score_next;
    logic                 matched_reg, matched_next;
    logic                 done_pe_reg, done_pe_next;

    logic [IDX_W-1:0]     rows_calc;
    logic                 sm_accept;
    logic                 rows_done;

    logic [SCORE_W-1:0]   ch_score [NUM_CH];
    logic [ID_W-1:0]      ch_id    [NUM_CH];
    logic [NUM_CH-1:0]    ch_live;
    logic [SCORE_W-1:0]   sel_score;
    logic [ID_W-1:0]      sel_id;

    // rows = ceil(count / NUM_CH)
    assign rows_calc = (IDX_W'(num_prev_objs) + IDX_W'(NUM_CH - 1)) / IDX_W'(NUM_CH);

    assign rows_done = (resp_cnt_reg == rows_reg);
    // Responses beyond the number of requested rows are dropped as well.
    assign sm_accept = sm_valid && !flush && !rows_done &&
                       ((state_reg == ST_REG) || (state_reg == ST_DRAIN));

    // Unpack channels; a channel past the object count (partial last row)
    // is not a candidate.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_score[gi] = sm_score[gi*SCORE_W +: SCORE_W];
            assign ch_id[gi]    = sm_id[gi*ID_W +: ID_W];
            assign ch_live[gi]  = (base_reg + IDX_W'(gi)) < IDX_W'(count_reg);
        end
    endgenerate

    // Fold the row into the running minimum. Strict less-than, scanning
    // channel 0 upwards, so ties keep the lower candidate index.
    always_comb begin
        sel_score = run_score_reg;
        sel_id    = run_id_reg;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_live[c] && (ch_score[c] < sel_score)) begin
                sel_score = ch_score[c];
                sel_id    = ch_id[c];
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (start_pe) state_next = ST_FE;
                ST_FE: begin
                    if (done_fe) begin
                        if (first_frame_reg || (count_reg == '0)) state_next = ST_DONE;
                        else                                      state_next = ST_REG;
                    end
                end
                // The request for the last row is on the outputs when
                // req_cnt reaches rows.
                ST_REG:   if (req_cnt_reg == rows_reg) state_next = ST_DRAIN;
                ST_DRAIN: if (rows_done) state_next = ST_DONE;
                ST_DONE:  state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: output next-values ----------------
    // Outputs are computed one cycle ahead and registered, so each pulse
    // coincides with the state it belongs to.
    always_comb begin
        start_fe_next   = (state_reg == ST_IDLE) && (state_next == ST_FE);
        row_req_next    = (state_next == ST_REG);
        row_sel_next    = (row_req_next && (state_reg == ST_REG)) ? ROW_W'(req_cnt_reg) : '0;
        done_pe_next    = (state_next == ST_DONE);
        best_id_next    = best_id_reg;
        best_score_next = best_score_reg;
        matched_next    = matched_reg;
        if (state_next == ST_DONE) begin
            if (state_reg == ST_FE) begin
                // Nothing to match against.
                best_id_next    = '0;
                best_score_next = '1;
                matched_next    = 1'b0;
            end else begin
                best_id_next    = run_id_reg;
                best_score_next = run_score_reg;
                matched_next    = (run_score_reg <= threshold_reg);
            end
        end
    end

    // ---------------- Datapath and output registers ----------------
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            count_reg       <= '0;
            first_frame_reg <= 1'b0;
            threshold_reg   <= '0;
            rows_reg        <= '0;
            req_cnt_reg     <= '0;
            resp_cnt_reg    <= '0;
            base_reg        <= '0;
            run_score_reg   <= '0;
            run_id_reg      <= '0;
            start_fe_reg    <= 1'b0;
            row_req_reg     <= 1'b0;
            row_sel_reg     <= '0;
            best_id_reg     <= '0;
            best_score_reg  <= '0;
            matched_reg     <= 1'b0;
            done_pe_reg     <= 1'b0;
        end else begin
            start_fe_reg    <= start_fe_next;
            row_req_reg     <= row_req_next;
            row_sel_reg     <= row_sel_next;
            best_id_reg     <= best_id_next;
            best_score_reg  <= best_score_next;
            matched_reg     <= matched_next;
            done_pe_reg     <= done_pe_next;

            if ((state_reg == ST_IDLE) && (state_next == ST_FE)) begin
                count_reg       <= num_prev_objs;
                first_frame_reg <= first_frame;
                threshold_reg   <= threshold;
                rows_reg        <= rows_calc[CNT_W-1:0];
            end

            if ((state_reg == ST_FE) && (state_next == ST_REG)) begin
                // Row 0 goes out on entry, so one request is already issued.
                req_cnt_reg   <= CNT_W'(1);
                resp_cnt_reg  <= '0;
                base_reg      <= '0;
                run_score_reg <= '1;
                run_id_reg    <= '0;
            end else if ((state_reg == ST_REG) && (state_next == ST_REG)) begin
                req_cnt_reg <= req_cnt_reg + CNT_W'(1);
            end else if (state_next == ST_IDLE) begin
                req_cnt_reg  <= '0;
                resp_cnt_reg <= '0;
                base_reg     <= '0;
            end

            if (sm_accept) begin
                resp_cnt_reg  <= resp_cnt_reg + CNT_W'(1);
                base_reg      <= base_reg + IDX_W'(NUM_CH);
                run_score_reg <= sel_score;
                run_id_reg    <= sel_id;
            end
        end
    end

    assign start_fe   = start_fe_reg;
    assign row_req    = row_req_reg;
    assign row_sel    = row_sel_reg;
    assign best_id    = best_id_reg;
    assign best_score = best_score_reg;
    assign matched    = matched_reg;
    assign done_pe    = done_pe_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule
